// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one spi_if master between NREQ requesters.
// Optional WAIT-state watchdog enabled with `define SPI_ARB_TIMEOUT_EN.

`ifndef DATAPATH_W
`define DATAPATH_W 8
`endif

module spi_arbiter #(
  parameter int NREQ      = 2,
  parameter int DATA_W    = `DATAPATH_W,
  parameter int TIMEOUT   = 64,
  parameter int TIMEOUT_W = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid_in,
  input  logic [NREQ-1:0]          req_write_in,
  input  logic [NREQ*DATA_W-1:0]   req_wdata_in,
  output logic [NREQ-1:0]          gnt_out,
  output logic [NREQ-1:0]          rsp_done_out,
  output logic [DATA_W-1:0]        rsp_rdata_out,
  output logic                     rsp_err_out,
  output logic                     busy_out,
  output logic                     spi_send_out,
  output logic                     spi_read_out,
  output logic [DATA_W-1:0]        spi_data_out,
  input  logic                     spi_ready_in,
  input  logic [DATA_W-1:0]        spi_rdata_in,
  output logic                     spi_abort_out
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  last_gnt_q;
  logic              write_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              send_q;
  logic              read_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 err_q;
  logic                 abort_q;
`endif

  logic              pick_valid_d;
  logic [IDX_W-1:0]  pick_idx_d;
  logic [IDX_W-1:0]  cand_idx;
  logic              pick_write_d;
  logic [DATA_W-1:0] pick_wdata_d;
  logic [NREQ-1:0]   pick_onehot_d;

  // Scan from last_gnt+1 upward; iterating from the far end lets the nearest
  // candidate overwrite the others, so the lowest offset wins.
  always_comb begin
    pick_valid_d = 1'b0;
    pick_idx_d   = last_gnt_q;
    cand_idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (int'(last_gnt_q) + k >= NREQ) begin
        cand_idx = IDX_W'(int'(last_gnt_q) + k - NREQ);
      end else begin
        cand_idx = IDX_W'(int'(last_gnt_q) + k);
      end
      if (req_valid_in[cand_idx]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = cand_idx;
      end
    end
    pick_write_d  = req_write_in[pick_idx_d];
    pick_wdata_d  = req_wdata_in[pick_idx_d*DATA_W +: DATA_W];
    pick_onehot_d = NREQ'(1) << pick_idx_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_gnt_q <= IDX_W'(NREQ - 1);
      write_q    <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      send_q     <= 1'b0;
      read_q     <= 1'b0;
      data_q     <= '0;
      rdata_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            state_q <= ISSUE;
            idx_q   <= pick_idx_d;
            write_q <= pick_write_d;
            data_q  <= pick_wdata_d;
            gnt_q   <= pick_onehot_d;
            send_q  <= pick_write_d;
            read_q  <= ~pick_write_d;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          send_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (spi_ready_in) begin
            state_q <= DONE;
            read_q  <= 1'b0;
            done_q  <= gnt_q;
            rdata_q <= write_q ? '0 : spi_rdata_in;
`ifdef SPI_ARB_TIMEOUT_EN
          end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
            // Ready has priority above; only a true stall reaches here.
            state_q <= DONE;
            read_q  <= 1'b0;
            done_q  <= gnt_q;
            rdata_q <= '0;
            err_q   <= 1'b1;
            abort_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        DONE: begin
          state_q    <= IDLE;
          last_gnt_q <= idx_q;
          gnt_q      <= '0;
          done_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
          err_q      <= 1'b0;
          abort_q    <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          send_q  <= 1'b0;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_out       = gnt_q;
  assign rsp_done_out  = done_q;
  assign rsp_rdata_out = rdata_q;
  assign busy_out      = (state_q != IDLE);
  assign spi_send_out  = send_q;
  assign spi_read_out  = read_q;
  assign spi_data_out  = data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign rsp_err_out   = err_q;
  assign spi_abort_out = abort_q;
`else
  assign rsp_err_out   = 1'b0;
  assign spi_abort_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: vector table plus hand-written corner
// sequences; completions are checked against a scoreboard queue.

module tb_spi_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO  = 8;
`else
  localparam int TMO  = 64;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid_in;
  logic [NREQ-1:0]   req_write_in;
  logic [NREQ*DW-1:0] req_wdata_in;
  logic [NREQ-1:0]   gnt_out;
  logic [NREQ-1:0]   rsp_done_out;
  logic [DW-1:0]     rsp_rdata_out;
  logic              rsp_err_out;
  logic              busy_out;
  logic              spi_send_out;
  logic              spi_read_out;
  logic [DW-1:0]     spi_data_out;
  logic              spi_ready_in;
  logic [DW-1:0]     spi_rdata_in;
  logic              spi_abort_out;

  spi_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_in (req_valid_in),
    .req_write_in (req_write_in),
    .req_wdata_in (req_wdata_in),
    .gnt_out      (gnt_out),
    .rsp_done_out (rsp_done_out),
    .rsp_rdata_out(rsp_rdata_out),
    .rsp_err_out  (rsp_err_out),
    .busy_out     (busy_out),
    .spi_send_out (spi_send_out),
    .spi_read_out (spi_read_out),
    .spi_data_out (spi_data_out),
    .spi_ready_in (spi_ready_in),
    .spi_rdata_in (spi_rdata_in),
    .spi_abort_out(spi_abort_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [DW-1:0]   rdata;
    logic            err;
  } exp_t;

  typedef struct {
    int              idx;
    bit              wr;
    logic [DW-1:0]   wdata;
    int              delay;
    logic [DW-1:0]   model_rdata;
    logic [NREQ-1:0] exp_gnt;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion monitor: every done strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && rsp_done_out != '0) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(rsp_done_out), 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("txn done=%b rdata=%h err=%b abort=%b", rsp_done_out, rsp_rdata_out,
                 rsp_err_out, spi_abort_out);
        chk("done_mask", 32'(rsp_done_out), 32'(e.done));
        chk("done_rdata", 32'(rsp_rdata_out), 32'(e.rdata));
        chk("done_err", 32'(rsp_err_out), 32'(e.err));
        chk("done_abort", 32'(spi_abort_out), 32'(e.err));
      end
    end
  end

  task automatic do_txn(input vec_t v);
    exp_t e;
    req_valid_in[v.idx]            = 1'b1;
    req_write_in[v.idx]            = v.wr;
    req_wdata_in[v.idx*DW +: DW]   = v.wdata;
    e.done = v.exp_gnt; e.rdata = v.exp_rdata; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    chk("issue_gnt", 32'(gnt_out), 32'(v.exp_gnt));
    chk("issue_send", 32'(spi_send_out), 32'(v.wr));
    chk("issue_read", 32'(spi_read_out), 32'(!v.wr));
    chk("issue_busy", 32'(busy_out), 32'd1);
    if (v.wr) chk("issue_data", 32'(spi_data_out), 32'(v.wdata));
    @(negedge clk);
    chk("wait_send", 32'(spi_send_out), 32'd0);
    chk("wait_read", 32'(spi_read_out), 32'(!v.wr));
    for (int k = 0; k < v.delay; k++) begin
      @(negedge clk);
      chk("wait_hold_read", 32'(spi_read_out), 32'(!v.wr));
      chk("wait_hold_gnt", 32'(gnt_out), 32'(v.exp_gnt));
    end
    spi_ready_in = 1'b1;
    spi_rdata_in = v.model_rdata;
    @(negedge clk);
    spi_ready_in = 1'b0;
    spi_rdata_in = '0;
    req_valid_in[v.idx] = 1'b0;
    chk("done_gnt", 32'(gnt_out), 32'(v.exp_gnt));
    @(negedge clk);
    chk("idle_busy", 32'(busy_out), 32'd0);
    chk("idle_done", 32'(rsp_done_out), 32'd0);
    chk("idle_gnt", 32'(gnt_out), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e;
    int   n;
    logic [NREQ-1:0] rr_exp;

    vecs[0] = '{0, 1'b1, 8'hA5, 10, 8'h77, 2'b01, 8'h00};
    vecs[1] = '{1, 1'b0, 8'h00,  3, 8'h3C, 2'b10, 8'h3C};
    vecs[2] = '{0, 1'b0, 8'hEE,  0, 8'h5A, 2'b01, 8'h5A};
    vecs[3] = '{1, 1'b1, 8'h0F,  2, 8'hC3, 2'b10, 8'h00};
    vecs[4] = '{1, 1'b0, 8'h11,  1, 8'h81, 2'b10, 8'h81};
    vecs[5] = '{0, 1'b1, 8'h96,  5, 8'h42, 2'b01, 8'h00};

    rst = 1'b0;
    req_valid_in = '0; req_write_in = '0; req_wdata_in = '0;
    spi_ready_in = 1'b0; spi_rdata_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt_out), 32'd0);
    chk("rst_done", 32'(rsp_done_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_send", 32'(spi_send_out), 32'd0);
    chk("rst_read", 32'(spi_read_out), 32'd0);
    chk("rst_data", 32'(spi_data_out), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata_out), 32'd0);
    chk("rst_err", 32'(rsp_err_out), 32'd0);
    chk("rst_abort", 32'(spi_abort_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Ready presented during ISSUE must be ignored.
    req_valid_in[1] = 1'b1; req_write_in[1] = 1'b1; req_wdata_in[DW +: DW] = 8'h3E;
    e.done = 2'b10; e.rdata = 8'h00; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    chk("ign_issue_send", 32'(spi_send_out), 32'd1);
    spi_ready_in = 1'b1; spi_rdata_in = 8'hAA;
    @(negedge clk);
    spi_ready_in = 1'b0;
    chk("ign_wait_done", 32'(rsp_done_out), 32'd0);
    chk("ign_wait_busy", 32'(busy_out), 32'd1);
    @(negedge clk);
    chk("ign_still_wait", 32'(rsp_done_out), 32'd0);
    spi_ready_in = 1'b1;
    @(negedge clk);
    spi_ready_in = 1'b0; spi_rdata_in = '0; req_valid_in = '0;
    @(negedge clk);

    // Request withdrawn during WAIT still completes.
    req_valid_in[0] = 1'b1; req_write_in[0] = 1'b0;
    e.done = 2'b01; e.rdata = 8'h9C; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    req_valid_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_busy", 32'(busy_out), 32'd1);
    chk("drop_read", 32'(spi_read_out), 32'd1);
    spi_ready_in = 1'b1; spi_rdata_in = 8'h9C;
    @(negedge clk);
    spi_ready_in = 1'b0; spi_rdata_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_no_restart", 32'(gnt_out), 32'd0);

    // Reset in the middle of a read held in WAIT.
    req_valid_in[1] = 1'b1; req_write_in[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wait_read", 32'(spi_read_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_read", 32'(spi_read_out), 32'd0);
    chk("arst_gnt", 32'(gnt_out), 32'd0);
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_data", 32'(spi_data_out), 32'd0);
    @(negedge clk);
    req_valid_in = 2'b11; req_write_in = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    // Both requesters continuously valid: grants must alternate from 0.
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (gnt_out == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      rr_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", 32'(gnt_out), 32'(rr_exp));
      e.done = rr_exp; e.rdata = DW'(8'h10 + i); e.err = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      spi_ready_in = 1'b1; spi_rdata_in = DW'(8'h10 + i);
      @(negedge clk);
      spi_ready_in = 1'b0; spi_rdata_in = '0;
      if (i == 3) req_valid_in = '0;
      @(negedge clk);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Ready never arrives: done+err+abort after TIMEOUT WAIT cycles.
    req_valid_in[0] = 1'b1; req_write_in[0] = 1'b0;
    e.done = 2'b01; e.rdata = 8'h00; e.err = 1'b1;
    sb_q.push_back(e);
    spi_rdata_in = 8'hDD;
    @(negedge clk);
    @(negedge clk);
    n = 1;
    while (rsp_done_out == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO + 1));
    req_valid_in = '0;
    @(negedge clk);
    chk("tmo_abort_one_cycle", 32'(spi_abort_out), 32'd0);
    chk("tmo_err_clear", 32'(rsp_err_out), 32'd0);

    // Ready on the final WAIT cycle wins over the timeout.
    req_valid_in[1] = 1'b1; req_write_in[1] = 1'b0;
    e.done = 2'b10; e.rdata = 8'h6B; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_last_busy", 32'(rsp_done_out), 32'd0);
    spi_ready_in = 1'b1; spi_rdata_in = 8'h6B;
    @(negedge clk);
    spi_ready_in = 1'b0; spi_rdata_in = '0; req_valid_in = '0;
    chk("tmo_race_err", 32'(rsp_err_out), 32'd0);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
